ps2_tx: RTL and testbench

//   Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset).
//   It sits beside the ps2 receiver on the same two open-drain lines and drives them low through output enables.

---
 rtl/ps2_tx_if.sv | 11 +
 rtl/ps2_tx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_tx_if.sv
// rtl/ps2_tx_if.sv - request/status bundle between a host and the PS/2 transmitter
interface ps2_tx_if;
  logic       wen;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output wen, output wdata, input busy, input done, input err);
  modport slave  (input wen, input wdata, output busy, output done, output err);
endinterface

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - host-to-device PS/2 command byte transmitter driving open-drain output enables
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned SETUP_CYCLES   = 200,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
  input  logic    clk,
  input  logic    reset,
  ps2_tx_if.slave bus,
  input  logic    ps2_clk_in,
  input  logic    ps2_data_in,
  output logic    ps2_clk_oe,
  output logic    ps2_data_oe
);

  localparam int unsigned PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CW = $clog2(PH_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT    = CW'(PH_MAX);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_SAT     = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t      r_state;
  logic        r_clk_s1, r_clk_s2, r_clk_prev;
  logic        r_data_s1, r_data_s2;
  logic [9:0]  r_frame;
  logic [3:0]  r_bit_cnt;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_to;
  logic        r_busy, r_done, r_err, r_clk_oe, r_data_oe;

  logic w_fall, w_accept, w_to_active, w_to_hit;

  assign w_fall      = r_clk_prev & ~r_clk_s2;
  assign w_accept    = (r_state == S_IDLE) && bus.wen && !r_busy;
  assign w_to_active = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  assign w_to_hit    = w_to_active && (r_to == TO_LAST);

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

  // Idle lines are high, so the synchronisers reset high to avoid a phantom fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= ps2_data_in;
      r_data_s2  <= r_data_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
      r_to      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (w_to_hit) begin
        r_err     <= 1'b1;
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_busy    <= 1'b0;
        r_state   <= S_IDLE;
      end else begin
        if (w_to_active && (r_to != TO_SAT)) begin
          r_to <= r_to + 1'b1;
        end

        unique case (r_state)
          S_IDLE: begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            if (w_accept) begin
              r_frame  <= {1'b1, ~^bus.wdata, bus.wdata};
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_clk_oe <= 1'b1;
              r_state  <= S_INHIBIT;
            end
          end

          S_INHIBIT: begin
            r_clk_oe  <= 1'b1;
            r_data_oe <= 1'b0;
            if (r_cnt == INH_LAST) begin
              r_cnt     <= '0;
              r_data_oe <= 1'b1;
              r_state   <= S_REQ;
            end else if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_REQ: begin
            r_data_oe <= 1'b1;
            if (r_cnt == SETUP_LAST) begin
              r_clk_oe  <= 1'b0;
              r_bit_cnt <= '0;
              r_to      <= '0;
              r_state   <= S_SEND;
            end else if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          // The tenth fall puts the stop bit out; the ack is taken on the eleventh.
          S_SEND: begin
            r_clk_oe <= 1'b0;
            if (w_fall && (r_bit_cnt <= 4'd9)) begin
              r_data_oe <= ~r_frame[r_bit_cnt];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 4'd9) begin
                r_state <= S_ACK;
              end
            end
          end

          S_ACK: begin
            if (w_fall) begin
              if (!r_data_s2) begin
                r_state <= S_WAIT_IDLE;
              end else begin
                r_err     <= 1'b1;
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_busy    <= 1'b0;
                r_state   <= S_IDLE;
              end
            end
          end

          S_WAIT_IDLE: begin
            if (r_clk_s2 && r_data_s2) begin
              r_done    <= 1'b1;
              r_clk_oe  <= 1'b0;
              r_data_oe <= 1'b0;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end
          end

          default: begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - scoreboard bench for ps2_tx with a behavioural PS/2 device on the open-drain lines
module tb_ps2_tx;
  localparam int INH = 20;
  localparam int SET = 5;
  localparam int TO  = 2000;
  localparam int HP  = 30;
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_RST = 3;

  typedef struct {
    logic [9:0] bits;
    logic       is_err;
    logic       check_bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk_oe, ps2_data_oe, ps2_clk_in, ps2_data_in;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  int   dev_mode = 0;
  int   dev_falls = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic [9:0] obs_q[$];

  ps2_tx_if bus();

  ps2_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst_n), .bus(bus),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  // Wired-AND of host and device pull-downs.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [9:0] wire_bits(input logic [7:0] b);
    int ones;
    logic [9:0] r;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[i];
      ones += int'(b[i]);
    end
    r[8] = (ones % 2 == 0);
    r[9] = 1'b1;
    return r;
  endfunction

  task automatic send(input logic [7:0] b, input int mode);
    exp_t e;
    int t;
    t = 0;
    while (bus.busy && t < 20000) begin @(negedge clk); t++; end
    e.bits       = wire_bits(b);
    e.is_err     = (mode != M_ACK);
    e.check_bits = (mode == M_ACK) || (mode == M_NACK);
    if (mode != M_RST) exp_q.push_back(e);
    dev_mode  = mode;
    bus.wen   = 1'b1;
    bus.wdata = b;
    @(negedge clk);
    bus.wen = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
  endtask

  task automatic wait_quiet();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < 20000) begin @(negedge clk); t++; end
    if (t >= 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL quiet_timeout: pending=%0d busy=%0b", exp_q.size(), bus.busy);
    end
    repeat (HP * 3) @(negedge clk);
  endtask

  // Monitor: every done/err retires exactly one expected transfer.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (bus.done || bus.err)) begin
      chk("done_err_exclusive", {31'd0, bus.done & bus.err}, 0);
      chk("busy_at_end", bus.busy, 0);
      chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: done=%0b err=%0b with nothing pending", bus.done, bus.err);
      end else begin
        e = exp_q.pop_front();
        chk("result_err", bus.err, e.is_err);
        chk("result_done", bus.done, !e.is_err);
        if (e.check_bits) begin
          if (obs_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_missing: no frame seen by device, expected %0h", e.bits);
          end else begin
            chk("frame_bits", obs_q.pop_front(), e.bits);
          end
        end
      end
    end
  end

  // Device: waits out the inhibit, then clocks 11 bits sampling on rising edges.
  initial begin : device
    logic [9:0] cap;
    int hi, dhi, mode;
    forever begin
      do @(negedge clk); while (ps2_clk_oe !== 1'b1);
      hi = 0;
      dhi = 0;
      while (ps2_clk_oe === 1'b1) begin
        hi++;
        if (ps2_data_oe) dhi++;
        @(negedge clk);
      end
      if (rst_n) begin
        chk("inhibit_len", hi, INH + SET);
        chk("start_setup_len", dhi, SET);
        mode = dev_mode;
        dev_falls = 0;
        if (mode != M_SILENT) begin
          repeat (HP) @(negedge clk);
          for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data_low = (mode == M_ACK);
            dev_clk_low = 1'b1;
            repeat (HP) @(negedge clk);
            if (k <= 10) cap[k-1] = ps2_data_in;
            dev_clk_low = 1'b0;
            dev_falls = k;
            if (mode == M_RST && k == 4) break;
            if (k == 10) obs_q.push_back(cap);
            repeat (HP) @(negedge clk);
          end
          dev_data_low = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : driver
    int t;
    logic [7:0] b;
    bus.wen   = 1'b0;
    bus.wdata = 8'h00;
    repeat (5) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.err, ps2_clk_oe, ps2_data_oe}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_outputs", {bus.busy, bus.done, bus.err, ps2_clk_oe, ps2_data_oe}, 0);

    send(8'hED, M_ACK); wait_quiet();
    send(8'h01, M_ACK); wait_quiet();
    send(8'h00, M_ACK); wait_quiet();
    send(8'hFF, M_ACK); wait_quiet();
    send(8'h3C, M_NACK); wait_quiet();

    send(8'hF0, M_SILENT);
    t = 0;
    while (ps2_clk_oe !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    t = 0;
    while (ps2_clk_oe !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
    t = 0;
    while (bus.err !== 1'b1 && t < TO + 20) begin @(negedge clk); t++; end
    chk("timeout_latency", t, TO);
    wait_quiet();

    send(8'hF4, M_ACK);
    repeat (200) @(negedge clk);
    chk("busy_mid_transfer", bus.busy, 1);
    bus.wen   = 1'b1;
    bus.wdata = 8'h55;
    @(negedge clk);
    bus.wen = 1'b0;
    wait_quiet();
    repeat (100) @(negedge clk);
    chk("dropped_write_no_restart", {bus.busy, ps2_clk_oe}, 0);

    send(8'hA5, M_RST);
    t = 0;
    while (dev_falls != 4 && t < 5000) begin @(negedge clk); t++; end
    chk("reset_setup_reached", dev_falls, 4);
    chk("pre_reset_state", {bus.busy, ps2_data_oe}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_releases", {bus.busy, ps2_clk_oe, ps2_data_oe, bus.done, bus.err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (HP * 3) @(negedge clk);
    send(8'hA5, M_ACK); wait_quiet();

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send(b, ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK);
      wait_quiet();
    end

    chk("scoreboard_drained", exp_q.size() + obs_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
